// File: rtl/eq_pipe_pkg.sv
// Shared types and constants for the E = 5A+5B-4C+3D equation pipeline.
//   word_t       16-bit result word
//   res_entry_t  FIFO entry: mismatch flag plus captured E
//   golden_e     reference E, 17-bit signed arithmetic wrapped to 16 bits
package eq_pipe_pkg;

    typedef logic [15:0] word_t;

    localparam int unsigned D_CONST_DEF = 768;
    localparam int unsigned LAT_DEF     = 3;

    typedef struct packed {
        logic  mism;
        word_t e;
    } res_entry_t;

    function automatic word_t golden_e(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [9:0] d);
        logic signed [16:0] av, bv, cv, dv, sum;
        av  = $signed({9'b0, a});
        bv  = $signed({9'b0, b});
        cv  = $signed({9'b0, c});
        dv  = $signed({7'b0, d});
        sum = 17'sd5 * av + 17'sd5 * bv - 17'sd4 * cv + 17'sd3 * dv;
        return sum[15:0];
    endfunction

endpackage

// File: rtl/eq_sync_fifo.sv
// Synchronous show-ahead FIFO holding result entries.
//   clk, rst     clock, asynchronous active-low reset
//   push, wdata  write request (ignored when full)
//   pop, rdata   read request (ignored when empty); rdata is the current head
//   full, empty  status; full is a registered flag
//   count        occupancy, 0..DEPTH
module eq_sync_fifo
    import eq_pipe_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = res_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q;
    logic            push_ok, pop_ok;

    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    // Storage needs no reset; the head is masked by empty at the top level.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/eq_result_sink.sv
// Consumer end of the E = 5A+5B-4C+3D stalled pipeline. Tracks issued ops through a LAT-deep
// valid pipe, captures e_in when the last stage is live, queues results in a FIFO and stalls the
// pipeline while the FIFO is full.
//   clk, rst            clock, asynchronous active-low reset
//   in_valid, A, B, C   operands issued to the pipeline this cycle
//   e_in                E from the pipeline's final stage
//   stall_o             freeze the pipeline (FIFO full)
//   out_valid/ready     read handshake; out_data/out_mism are the head entry
//   fifo_cnt            FIFO occupancy
//   res_cnt, err_cnt    pushes since reset (wraps), mismatches since reset (saturates)
// Optional: define EQ_SINK_CHECK_EN to add a shadow golden-model pipe and mismatch checking.
module eq_result_sink
    import eq_pipe_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned LAT     = LAT_DEF,
    parameter int unsigned D_CONST = D_CONST_DEF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             A,
    input  logic [7:0]             B,
    input  logic [7:0]             C,
    input  logic [15:0]            e_in,
    output logic                   stall_o,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_data,
    output logic                   out_mism,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic [CNT_W-1:0]       res_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam logic [9:0] D10 = D_CONST[9:0];

    logic [LAT-1:0]   vld_q, vld_d;
    logic [LAT:0]     vld_shift;
    logic             full, empty, push, pop, mism;
    res_entry_t       wr_entry, rd_entry;
    logic [CNT_W-1:0] res_q;

    // Stall comes straight from the FIFO's registered full flag.
    assign stall_o = full;

    assign vld_shift = {vld_q, in_valid};
    assign vld_d     = vld_shift[LAT-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (!stall_o) begin
            vld_q <= vld_d;
        end
    end

    // While frozen the last stage holds its op; it is pushed once the stall drops.
    assign push = vld_q[LAT-1] & ~stall_o;
    assign pop  = out_valid & out_ready;

    assign wr_entry = '{mism: mism, e: e_in};

    eq_sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (res_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    assign out_valid = ~empty;
    assign out_data  = out_valid ? rd_entry.e : '0;
    assign out_mism  = out_valid & rd_entry.mism;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q <= '0;
        end else if (push) begin
            res_q <= res_q + CNT_W'(1);
        end
    end
    assign res_cnt = res_q;

`ifdef EQ_SINK_CHECK_EN
    word_t            exp_q [LAT];
    logic [CNT_W-1:0] err_q;

    // Shadow pipe advances in lockstep with vld_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) exp_q[i] <= '0;
        end else if (!stall_o) begin
            exp_q[0] <= golden_e(A, B, C, D10);
            for (int i = 1; i < LAT; i++) exp_q[i] <= exp_q[i-1];
        end
    end

    assign mism = (e_in != exp_q[LAT-1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else if (push && mism && (err_q != '1)) begin
            err_q <= err_q + CNT_W'(1);
        end
    end
    assign err_cnt = err_q;
`else
    logic unused_ops;
    assign unused_ops = ^{A, B, C, D10};
    assign mism       = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_eq_result_sink.sv
module tb_eq_result_sink;
    import eq_pipe_pkg::*;

`ifdef EQ_SINK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  A = '0, B = '0, C = '0;
    logic [15:0] e_in;
    logic        stall_o, out_valid, out_mism;
    logic [15:0] out_data;
    logic [3:0]  fifo_cnt;
    logic [15:0] res_cnt, err_cnt;

    always #5 clk = ~clk;

    eq_result_sink dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .C         (C),
        .e_in      (e_in),
        .stall_o   (stall_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mism  (out_mism),
        .fifo_cnt  (fifo_cnt),
        .res_cnt   (res_cnt),
        .err_cnt   (err_cnt)
    );

    // Directed vectors with hand-computed E = 5A+5B-4C+2304.
    logic [7:0]  va [12] = '{8'd1, 8'd255, 8'd0, 8'd255, 8'd0, 8'd10, 8'd100, 8'd0, 8'd7,
                             8'd50, 8'd200, 8'd128};
    logic [7:0]  vb [12] = '{8'd1, 8'd255, 8'd0, 8'd255, 8'd0, 8'd20, 8'd0, 8'd0, 8'd3,
                             8'd50, 8'd1, 8'd64};
    logic [7:0]  vc [12] = '{8'd1, 8'd0, 8'd255, 8'd255, 8'd0, 8'd30, 8'd0, 8'd1, 8'd2,
                             8'd100, 8'd13, 8'd32};
    logic [15:0] ve [12] = '{16'd2310, 16'd4854, 16'd1284, 16'd3834, 16'd2304, 16'd2334,
                             16'd2804, 16'd2300, 16'd2346, 16'd2404, 16'd3257, 16'd3136};

    typedef struct packed {
        logic [15:0] e;
        logic        m;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   n_sampled = 0;
    int   dropped [$];

    // Behavioural stand-in for the 3-stage stalled equation pipeline.
    logic        pv [3];
    logic [15:0] pe [3];
    logic        pc [3];
    logic        corrupt = 1'b0;

    function automatic logic [15:0] pipe_e(input logic [7:0] a, b, c);
        int s;
        s = 5 * int'(a) + 5 * int'(b) - 4 * int'(c) + 3 * 768;
        return s[15:0];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                pv[i] <= 1'b0;
                pe[i] <= '0;
                pc[i] <= 1'b0;
            end
        end else if (!stall_o) begin
            pv[0] <= in_valid;
            pe[0] <= pipe_e(A, B, C);
            pc[0] <= corrupt;
            for (int i = 1; i < 3; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pc[i] <= pc[i-1];
            end
        end
    end

    // Garbage when the last stage is empty so stray captures show up.
    assign e_in = !pv[2] ? 16'hdead : (pc[2] ? 16'h0000 : pe[2]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare the head whenever it is accepted.
    always @(negedge clk) begin
        exp_t x;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got data %0d expected no result", out_data);
            end else begin
                x = sb.pop_front();
                check("pop_data", {16'd0, out_data}, {16'd0, x.e});
                check("pop_mism", {31'd0, out_mism}, {31'd0, x.m});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one op for one cycle; expected result queued only if the DUT samples it.
    task automatic issue(input int idx, input bit bad);
        exp_t x;
        in_valid = 1'b1;
        A        = va[idx];
        B        = vb[idx];
        C        = vc[idx];
        corrupt  = bad;
        if (!stall_o) begin
            x.e = bad ? 16'd0 : ve[idx];
            x.m = bad & CHK;
            sb.push_back(x);
            n_sampled++;
        end else begin
            dropped.push_back(idx);
        end
        tick();
        in_valid = 1'b0;
        corrupt  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_stall"},  {31'd0, stall_o},   32'd0);
        check({name, "_valid"},  {31'd0, out_valid}, 32'd0);
        check({name, "_data"},   {16'd0, out_data},  32'd0);
        check({name, "_mism"},   {31'd0, out_mism},  32'd0);
        check({name, "_cnt"},    {28'd0, fifo_cnt},  32'd0);
        check({name, "_res"},    {16'd0, res_cnt},   32'd0);
        check({name, "_err"},    {16'd0, err_cnt},   32'd0);
    endtask

    initial begin
        int n;
        // Initial reset.
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Single op: result visible three edges after the issue edge.
        out_ready = 1'b1;
        issue(0, 1'b0);
        for (int j = 0; j <= 3; j++) begin
            @(negedge clk);
            check("latency_valid", {31'd0, out_valid}, {31'd0, (j == 3)});
            if (j < 3) tick();
        end
        tick();
        drain("single");
        check("single_res_cnt", {16'd0, res_cnt}, 32'd1);

        // Extremes back to back.
        for (int i = 1; i <= 3; i++) issue(i, 1'b0);
        drain("extremes");

        // One corrupted E among good ones.
        issue(4, 1'b0);
        issue(5, 1'b1);
        issue(6, 1'b0);
        drain("corrupt");
        check("corrupt_err_cnt", {16'd0, err_cnt}, {31'd0, CHK});

        // Backpressure: 12 ops into a stopped reader.
        out_ready = 1'b0;
        dropped.delete();
        for (int i = 0; i < 12; i++) issue(i, 1'b0);
        tick();
        tick();
        @(negedge clk);
        check("bp_fifo_full", {28'd0, fifo_cnt}, 32'd8);
        check("bp_stall", {31'd0, stall_o}, 32'd1);
        check("bp_dropped", dropped.size(), 32'd1);

        // Pop one while full: stall falls, then the frozen op fills the slot.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("pop_full_stall", {31'd0, stall_o}, 32'd0);
        check("pop_full_cnt", {28'd0, fifo_cnt}, 32'd7);
        tick();
        @(negedge clk);
        check("refill_cnt", {28'd0, fifo_cnt}, 32'd8);
        check("refill_stall", {31'd0, stall_o}, 32'd1);

        // Drain and reissue what was refused during the stall.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        while (dropped.size() != 0) begin
            n = dropped.pop_front();
            begin
                int w;
                w = 0;
                while (stall_o && w < 20) begin
                    tick();
                    w++;
                end
            end
            issue(n, 1'b0);
        end
        drain("backpressure");
        check("bp_res_cnt", {16'd0, res_cnt}, n_sampled);
        check("bp_err_cnt", {16'd0, err_cnt}, {31'd0, CHK});

        // Mid-stream reset drops everything in flight.
        out_ready = 1'b0;
        for (int i = 7; i <= 10; i++) issue(i, 1'b0);
        tick();
        #3 rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        n_sampled = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("post_reset_cnt", {28'd0, fifo_cnt}, 32'd0);
        check("post_reset_res", {16'd0, res_cnt}, 32'd0);
        check("post_reset_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        issue(11, 1'b0);
        drain("post_reset");
        check("post_reset_res1", {16'd0, res_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
